guess_ranker: RTL and testbench



---
 rtl/guess_ranker_pkg.sv | 51 +++++
 rtl/guess_ranker_if.sv | 38 +++
 rtl/guess_ranker_char_decode.sv | 70 +++++++
 rtl/guess_ranker.sv | 110 +++++++++++
 tb/tb_guess_ranker.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/guess_ranker_pkg.sv
// guess_ranker_pkg
// Shared definitions for the guess ranker: charset numbering, charset
// sizes, the default maximum guess length and the ranker FSM state type.
// Contents:
//   MAXLEN / IDXW        default guess length and index accumulator width
//   CS_*                 charset numbers
//   SZ_*                 number of symbols in each charset
//   charset_size()       charset number -> radix (0 for invalid charsets)
//   rank_state_t         IDLE / SCAN / DONE
package guess_ranker_pkg;

   localparam int MAXLEN = 16;
   localparam int IDXW   = 8 * MAXLEN;

   localparam logic [2:0] CS_LOWER = 3'd0;
   localparam logic [2:0] CS_UPPER = 3'd1;
   localparam logic [2:0] CS_ALPHA = 3'd2;
   localparam logic [2:0] CS_ALNUM = 3'd3;
   localparam logic [2:0] CS_KEYB  = 3'd4;
   localparam logic [2:0] CS_FULL  = 3'd5;

   localparam logic [8:0] SZ_LOWER = 9'd26;
   localparam logic [8:0] SZ_UPPER = 9'd26;
   localparam logic [8:0] SZ_ALPHA = 9'd52;
   localparam logic [8:0] SZ_ALNUM = 9'd62;
   localparam logic [8:0] SZ_KEYB  = 9'd94;
   localparam logic [8:0] SZ_FULL  = 9'd256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } rank_state_t;

   // Radix of a charset; invalid charsets report 0 (never used, since
   // every character of an invalid charset fails decode).
   function automatic logic [8:0] charset_size(input logic [2:0] cs);
      logic [8:0] sz;
      case (cs)
         CS_LOWER: sz = SZ_LOWER;
         CS_UPPER: sz = SZ_UPPER;
         CS_ALPHA: sz = SZ_ALPHA;
         CS_ALNUM: sz = SZ_ALNUM;
         CS_KEYB:  sz = SZ_KEYB;
         CS_FULL:  sz = SZ_FULL;
         default:  sz = 9'd0;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/guess_ranker_if.sv
// guess_ranker_if
// Request/result bundle between the hash-match side (master) and the
// ranker (slave).
//   start     request pulse
//   charset   charset number
//   guesslen  guess length, 0 means MAXLEN
//   guess     ASCII guess, digit i in [8*MAXLEN-1-8i -: 8]
//   busy      ranker is working on an accepted request
//   done      one-cycle completion pulse
//   index     linear keyspace index of the guess
//   error     guess contained a non-member character / bad charset
//   badpos    digit position of the first offending character
interface guess_ranker_if #(
   parameter int MAXLEN = 16,
   parameter int IDXW   = 8 * MAXLEN
);
   localparam int PW = $clog2(MAXLEN);

   logic                  start;
   logic [2:0]            charset;
   logic [PW-1:0]         guesslen;
   logic [8*MAXLEN-1:0]   guess;
   logic                  busy;
   logic                  done;
   logic [IDXW-1:0]       index;
   logic                  error;
   logic [PW-1:0]         badpos;

   modport master (
      output start, charset, guesslen, guess,
      input  busy, done, index, error, badpos
   );

   modport slave (
      input  start, charset, guesslen, guess,
      output busy, done, index, error, badpos
   );
endinterface

// File: rtl/guess_ranker_char_decode.sv
// char_decode
// Combinational character-to-digit decode; this is the reference for the
// shared charset table contents.
//   i_charset  charset number (6,7 invalid)
//   i_byte     ASCII character
//   o_valid    character is a member of the charset
//   o_digit    digit value of the character (0 when not valid)
module char_decode
   import guess_ranker_pkg::*;
(
   input  logic [2:0] i_charset,
   input  logic [7:0] i_byte,
   output logic       o_valid,
   output logic [7:0] o_digit
);
   logic w_lower;
   logic w_upper;
   logic w_num;
   logic w_keyb;

   assign w_lower = (i_byte >= 8'h61) && (i_byte <= 8'h7A);
   assign w_upper = (i_byte >= 8'h41) && (i_byte <= 8'h5A);
   assign w_num   = (i_byte >= 8'h30) && (i_byte <= 8'h39);
   assign w_keyb  = (i_byte >= 8'h21) && (i_byte <= 8'h7E);

   always_comb begin
      o_valid = 1'b0;
      o_digit = 8'd0;
      case (i_charset)
         CS_LOWER: begin
            if (w_lower) begin
               o_valid = 1'b1;
               o_digit = i_byte - 8'h61;
            end
         end
         CS_UPPER: begin
            if (w_upper) begin
               o_valid = 1'b1;
               o_digit = i_byte - 8'h41;
            end
         end
         CS_ALPHA, CS_ALNUM: begin
            if (w_lower) begin
               o_valid = 1'b1;
               o_digit = i_byte - 8'h61;
            end else if (w_upper) begin
               o_valid = 1'b1;
               o_digit = i_byte - 8'h41 + 8'd26;
            end else if (w_num && (i_charset == CS_ALNUM)) begin
               o_valid = 1'b1;
               o_digit = i_byte - 8'h30 + 8'd52;
            end
         end
         CS_KEYB: begin
            if (w_keyb) begin
               o_valid = 1'b1;
               o_digit = i_byte - 8'h21;
            end
         end
         CS_FULL: begin
            o_valid = 1'b1;
            o_digit = i_byte;
         end
         default: begin
            o_valid = 1'b0;
            o_digit = 8'd0;
         end
      endcase
   end
endmodule

// File: rtl/guess_ranker.sv
// guess_ranker
// Recovers the linear keyspace index of an ASCII guess: one digit per
// clock, most significant digit (position L-1) first, Horner accumulation.
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    guess_ranker_if slave: start/charset/guesslen/guess in,
//          busy/done/index/error/badpos out
module guess_ranker
   import guess_ranker_pkg::*;
#(
   parameter int MAXLEN = guess_ranker_pkg::MAXLEN,
   parameter int IDXW   = 8 * MAXLEN
) (
   input  logic           clk,
   input  logic           reset,
   guess_ranker_if.slave  bus
);
   localparam int PW = $clog2(MAXLEN);

   rank_state_t           r_state;
   logic [2:0]            r_charset;
   logic [8:0]            r_size;
   logic [8*MAXLEN-1:0]   r_guess;
   logic [PW-1:0]         r_pos;
   logic [IDXW-1:0]       r_acc;
   logic [IDXW-1:0]       r_index;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic [PW-1:0]         r_badpos;

   logic [7:0]            w_byte;
   logic                  w_valid;
   logic [7:0]            w_digit;

   // Digit 0 sits in the top byte, so position p is counted down from the MSB.
   assign w_byte = r_guess[(8*MAXLEN-1) - 8*int'(r_pos) -: 8];

   char_decode u_decode (
      .i_charset (r_charset),
      .i_byte    (w_byte),
      .o_valid   (w_valid),
      .o_digit   (w_digit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_charset <= 3'd0;
         r_size    <= 9'd0;
         r_guess   <= '0;
         r_pos     <= '0;
         r_acc     <= '0;
         r_index   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_badpos  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_charset <= bus.charset;
                  r_size    <= charset_size(bus.charset);
                  r_guess   <= bus.guess;
                  // Length 0 encodes the full MAXLEN characters.
                  r_pos     <= (bus.guesslen == '0) ? PW'(MAXLEN - 1)
                                                    : bus.guesslen - 1'b1;
                  r_acc     <= '0;
                  r_error   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (w_valid) begin
                  // Truncation is lossless: the largest result is 2^IDXW-1.
                  r_acc <= r_acc * IDXW'(r_size) + IDXW'(w_digit);
                  if (r_pos == '0) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_pos <= r_pos - 1'b1;
                  end
               end else begin
                  r_error  <= 1'b1;
                  r_badpos <= r_pos;
                  r_acc    <= '0;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_index <= r_acc;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.index  = r_index;
   assign bus.error  = r_error;
   assign bus.badpos = r_badpos;
endmodule

// File: tb/tb_guess_ranker.sv
module tb_guess_ranker;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   opnum  = 0;

   logic [7:0] alpha [8][$];

   guess_ranker_if bus ();

   guess_ranker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: digit = position of the character in the charset's ordered
   // symbol list; index = sum digit[i]*size^i; first failure from the top.
   task automatic model(input logic [2:0] cs, input logic [3:0] gl, input logic [127:0] g,
                        output logic [127:0] idx, output logic err,
                        output logic [3:0] bp, output int lat);
      int L;
      int d [16];
      logic [127:0] p;
      logic [7:0] c;
      int sz;
      L = (gl == 0) ? 16 : int'(gl);
      sz = alpha[cs].size();
      err = 1'b0;
      bp = 4'd0;
      idx = '0;
      lat = L + 1;
      for (int i = L - 1; i >= 0; i--) begin
         c = g[127 - 8*i -: 8];
         d[i] = -1;
         for (int k = 0; k < sz; k++)
            if (alpha[cs][k] == c) d[i] = k;
         if (d[i] < 0) begin
            err = 1'b1;
            bp = 4'(i);
            lat = L - i + 1;
            break;
         end
      end
      if (!err) begin
         p = 128'd1;
         for (int i = 0; i < L; i++) begin
            idx = idx + 128'(d[i]) * p;
            p = p * 128'(sz);
         end
      end
   endtask

   // Issues one request (start sampled at the next edge), waits for done
   // and compares everything against the model. With scramble set, the
   // request inputs are churned and extra starts are pulsed during the scan.
   task automatic run_op(input logic [2:0] cs, input logic [3:0] gl,
                         input logic [127:0] g, input bit scramble);
      logic [127:0] e_idx;
      logic e_err;
      logic [3:0] e_bp;
      int e_lat;
      int lat;
      model(cs, gl, g, e_idx, e_err, e_bp, e_lat);
      opnum++;
      bus.charset  = cs;
      bus.guesslen = gl;
      bus.guess    = g;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("accept_busy", 128'(bus.busy), 128'd1);
      check("accept_error_clear", 128'(bus.error), 128'd0);
      check("accept_done_low", 128'(bus.done), 128'd0);
      lat = 0;
      while (!bus.done && lat < 40) begin
         if (scramble) begin
            bus.start    = 1'($urandom % 2);
            bus.charset  = 3'($urandom);
            bus.guesslen = 4'($urandom);
            bus.guess    = {$urandom, $urandom, $urandom, $urandom};
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      check("latency", 128'(lat), 128'(e_lat));
      check("index", bus.index, e_idx);
      check("error", 128'(bus.error), 128'(e_err));
      if (e_err) check("badpos", 128'(bus.badpos), 128'(e_bp));
      check("done_busy_low", 128'(bus.busy), 128'd0);
      $display("op %0d: cs=%0d len=%0d index=%0h error=%0d badpos=%0d latency=%0d",
               opnum, cs, gl, bus.index, bus.error, bus.badpos, lat);
   endtask

   initial begin
      logic [127:0] g;
      logic [2:0] cs;
      int seen;
      for (int c = 8'h61; c <= 8'h7A; c++) begin
         alpha[0].push_back(8'(c)); alpha[2].push_back(8'(c)); alpha[3].push_back(8'(c));
      end
      for (int c = 8'h41; c <= 8'h5A; c++) begin
         alpha[1].push_back(8'(c)); alpha[2].push_back(8'(c)); alpha[3].push_back(8'(c));
      end
      for (int c = 8'h30; c <= 8'h39; c++) alpha[3].push_back(8'(c));
      for (int c = 8'h21; c <= 8'h7E; c++) alpha[4].push_back(8'(c));
      for (int c = 0; c < 256; c++) alpha[5].push_back(8'(c));

      bus.start = 1'b0; bus.charset = 3'd0; bus.guesslen = 4'd0; bus.guess = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_done", 128'(bus.done), 128'd0);
      check("rst_index", bus.index, 128'd0);
      check("rst_error", 128'(bus.error), 128'd0);
      check("rst_badpos", 128'(bus.badpos), 128'd0);
      $display("reset: busy=%0d done=%0d index=%0h", bus.busy, bus.done, bus.index);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed cases with hand-derived expectations.
      run_op(3'd0, 4'd2, {"ba", 112'h0}, 1'b0);
      check("ba_index", bus.index, 128'd1);
      run_op(3'd3, 4'd1, {"9", 120'h0}, 1'b0);
      check("nine_index", bus.index, 128'd61);
      run_op(3'd3, 4'd1, {"Z", 120'h0}, 1'b0);
      check("Z_index", bus.index, 128'd51);
      run_op(3'd5, 4'd0, {128{1'b1}}, 1'b0);
      check("full_index", bus.index, {128{1'b1}});
      run_op(3'd0, 4'd3, {"aAz", 104'h0}, 1'b0);
      check("aAz_badpos", 128'(bus.badpos), 128'd1);
      run_op(3'd6, 4'd4, {"abcd", 96'h0}, 1'b0);
      check("cs6_badpos", 128'(bus.badpos), 128'd3);
      // Starts and input churn during the scan must not disturb the result.
      run_op(3'd4, 4'd0, {"~!Hello,World?#", 8'h7E}, 1'b1);
      // Nothing further may complete after a single done.
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.done) seen++;
      end
      check("no_second_done", 128'(seen), 128'd0);

      // Reset in the middle of a scan aborts with no done pulse.
      bus.charset = 3'd5; bus.guesslen = 4'd0; bus.guess = {128{1'b1}}; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_busy", 128'(bus.busy), 128'd0);
      check("midrst_done", 128'(bus.done), 128'd0);
      check("midrst_index", bus.index, 128'd0);
      seen = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.done) seen++;
      end
      check("midrst_no_done", 128'(seen), 128'd0);
      $display("mid-scan reset: busy=%0d done pulses=%0d index=%0h", bus.busy, seen, bus.index);

      run_op(3'd2, 4'd5, {"qWeRt", 88'hFF_00}, 1'b0);

      // Randomized, back-to-back, mostly legal characters, random padding.
      for (int n = 0; n < 150; n++) begin
         cs = 3'($urandom_range(0, 7));
         for (int i = 0; i < 16; i++) begin
            if (cs <= 3'd5 && ($urandom % 16) != 0)
               g[127 - 8*i -: 8] = alpha[cs][$urandom_range(0, alpha[cs].size() - 1)];
            else
               g[127 - 8*i -: 8] = 8'($urandom);
         end
         run_op(cs, 4'($urandom), g, bit'($urandom % 4 == 0));
         if ($urandom % 3 == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
